mp_add_arb: RTL

MP_ADD_ARB -- requirements
Module: mp_add_arb

---
 rtl/mp_add_arb_pkg.sv | 13 +
 rtl/mp_add_arb_fa_par.sv | 18 +
 rtl/mp_add_arb.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mp_add_arb_pkg.sv
// Shared types and defaults for the arbitrated multi-word adder.
package mp_add_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int unsigned DEF_N     = 4;
   localparam int unsigned DEF_WORDS = 4;

endpackage

// File: rtl/mp_add_arb_fa_par.sv
// N-bit parallel adder with carry-in and carry-out.
module fa_par #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         carry
);

   logic [N:0] w_sum;

   assign w_sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
   assign sum   = w_sum[N-1:0];
   assign carry = w_sum[N];

endmodule

// File: rtl/mp_add_arb.sv
// Two-requester round-robin front end to a word-serial multi-word adder.
module mp_add_arb
   import mp_add_arb_pkg::*;
#(
   parameter int unsigned N     = DEF_N,
   parameter int unsigned WORDS = DEF_WORDS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [N*WORDS-1:0]   req0_a,
   input  logic [N*WORDS-1:0]   req0_b,
   input  logic                 req0_cin,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [N*WORDS-1:0]   req1_a,
   input  logic [N*WORDS-1:0]   req1_b,
   input  logic                 req1_cin,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [N*WORDS-1:0]   res_sum,
   output logic                 res_carry,
   output logic                 res_id
);

   localparam int unsigned W  = N * WORDS;
   localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   state_t         r_state;
   state_t         w_state_nxt;
   logic           r_ptr;
   logic           r_id;
   logic           r_cy;
   logic           r_res_cy;
   logic [IW-1:0]  r_idx;
   logic [W-1:0]   r_a;
   logic [W-1:0]   r_b;
   logic [W-1:0]   r_sum;

   logic           w_any;
   logic           w_gnt;
   logic           w_acc;
   logic           w_last;
   logic [N-1:0]   w_wa;
   logic [N-1:0]   w_wb;
   logic [N-1:0]   w_ws;
   logic           w_wc;

   // r_ptr names the requester that wins a tie.
   always_comb begin
      w_any = req0_valid | req1_valid;
      w_gnt = 1'b0;
      unique case (1'b1)
         (req0_valid && req1_valid):  w_gnt = r_ptr;
         (req1_valid && !req0_valid): w_gnt = 1'b1;
         (req0_valid && !req1_valid): w_gnt = 1'b0;
         default:                     w_gnt = 1'b0;
      endcase
   end

   assign w_acc      = (r_state == ST_IDLE) && rst_n && w_any;
   assign req0_ready = w_acc && !w_gnt;
   assign req1_ready = w_acc && w_gnt;
   assign w_last     = (r_idx == LAST);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (w_acc)     w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
         ST_DONE: if (res_ready) w_state_nxt = ST_IDLE;
         default:                w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   assign w_wa = r_a[r_idx*N +: N];
   assign w_wb = r_b[r_idx*N +: N];

   fa_par #(
      .N (N)
   ) u_add (
      .a     (w_wa),
      .b     (w_wb),
      .cin   (r_cy),
      .sum   (w_ws),
      .carry (w_wc)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr    <= 1'b0;
         r_id     <= 1'b0;
         r_cy     <= 1'b0;
         r_res_cy <= 1'b0;
         r_idx    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_sum    <= '0;
      end else if (w_acc) begin
         r_a   <= w_gnt ? req1_a : req0_a;
         r_b   <= w_gnt ? req1_b : req0_b;
         r_cy  <= w_gnt ? req1_cin : req0_cin;
         r_id  <= w_gnt;
         r_ptr <= ~w_gnt;
         r_idx <= '0;
      end else if (r_state == ST_RUN) begin
         r_sum[r_idx*N +: N] <= w_ws;
         r_cy  <= w_wc;
         r_idx <= r_idx + IW'(1);
         if (w_last) r_res_cy <= w_wc;
      end
   end

   assign res_valid = (r_state == ST_DONE);
   assign res_sum   = r_sum;
   assign res_carry = r_res_cy;
   assign res_id    = r_id;

endmodule
